// File: rtl/rr_pkt_arbiter.sv
// Round-robin packet arbiter: N sources share one valid/ready channel, and the grant stays locked for a whole packet.
// Optional ARB_OUT_REG_EN macro registers the output through a 2-entry skid buffer.
module rr_pkt_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            in_valid,
   output logic [NUM_REQ-1:0]            in_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_REQ-1:0]            in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_last,
   output logic [ID_WIDTH-1:0]           out_id,
   output logic                          busy
);

   typedef enum logic {IDLE, LOCK} state_t;

   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   state_t               state, state_nx;
   logic [NUM_REQ-1:0]   pri, pri_nx, lock_gnt, lock_nx;
   logic [NUM_REQ-1:0]   req_hi, pick, gnt;
   logic                 sel_valid, sel_last, accept;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [ID_WIDTH-1:0]  sel_id;

   function automatic logic [NUM_REQ-1:0] rotl(input logic [NUM_REQ-1:0] x);
      return {x[NUM_REQ-2:0], x[NUM_REQ-1]};
   endfunction

   // Requests at or above the pointer win; otherwise wrap to the lowest request.
   always_comb begin
      req_hi = in_valid & ~(pri - ONE);
      if (|req_hi) pick = req_hi & (~req_hi + ONE);
      else         pick = in_valid & (~in_valid + ONE);
   end

   assign gnt       = (state == LOCK) ? lock_gnt : pick;
   assign sel_valid = |(in_valid & gnt);
   assign busy      = (state == LOCK);

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      sel_id   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_last = in_last[i];
            sel_id   = ID_WIDTH'(i);
         end
      end
   end

   always_comb begin
      state_nx = state;
      pri_nx   = pri;
      lock_nx  = lock_gnt;
      case (state)
         IDLE: begin
            if (accept && sel_last) begin
               pri_nx = rotl(gnt);
            end else if (sel_valid) begin
               state_nx = LOCK;
               lock_nx  = pick;
            end
         end
         LOCK: begin
            if (accept && sel_last) begin
               state_nx = IDLE;
               pri_nx   = rotl(lock_gnt);
               lock_nx  = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pri      <= ONE;
         lock_gnt <= '0;
      end else begin
         state    <= state_nx;
         pri      <= pri_nx;
         lock_gnt <= lock_nx;
      end
   end

`ifdef ARB_OUT_REG_EN
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
      logic [ID_WIDTH-1:0]   id;
   } beat_t;

   beat_t       skid [2];
   beat_t       beat_in;
   logic [1:0]  cnt;
   logic        full, pop;

   assign beat_in  = '{data: sel_data, last: sel_last, id: sel_id};
   assign full     = (cnt == 2'd2);
   assign in_ready = gnt & {NUM_REQ{~full}};
   assign accept   = sel_valid & ~full;
   assign pop      = out_valid & out_ready;

   // Entry 0 is always the head; a push while popping a single entry refills it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 2'd0;
      end else begin
         case ({accept, pop})
            2'b10: begin
               skid[cnt[0]] <= beat_in;
               cnt          <= cnt + 2'd1;
            end
            2'b01: begin
               skid[0] <= skid[1];
               cnt     <= cnt - 2'd1;
            end
            2'b11: skid[0] <= beat_in;
            default: ;
         endcase
      end
   end

   assign out_valid = (cnt != 2'd0);
   assign out_data  = skid[0].data;
   assign out_last  = skid[0].last;
   assign out_id    = skid[0].id;
`else
   assign in_ready  = gnt & {NUM_REQ{out_ready}};
   assign accept    = sel_valid & out_ready;
   assign out_valid = sel_valid;
   assign out_data  = sel_data;
   assign out_last  = sel_last;
   assign out_id    = sel_id;
`endif

endmodule

// File: doc/rr_pkt_arbiter.md
Name: rr_pkt_arbiter

Overview:
- Shares one valid/ready downstream channel among NUM_REQ upstream packet sources, for example per-warp memory request queues feeding one L1/LSU port.
- Selects a source with a rotating-priority round-robin pick.
- Once a packet's first beat is offered, the grant is locked to that source until its last beat is accepted, so packets never interleave.
- Priority rotates only at packet boundaries.

Parameters:
- NUM_REQ, 4, number of requesters (2 or more).
- DATA_WIDTH, 32, payload width per beat.
- ID_WIDTH, 2, width of out_id; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_REQ  per-requester beat valid.
- in_ready  out  NUM_REQ  per-requester beat accepted.
- in_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  NUM_REQ  marks the final beat of a packet.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_WIDTH  payload of the selected requester.
- out_last  out  1  last flag of the selected requester.
- out_id  out  ID_WIDTH  binary index of the granted requester.
- busy  out  1  high while in the LOCK state.

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high. Reset is the only reset path.
- Registers:
  - pri: one-hot priority pointer; reset value 1 (requester 0 highest).
  - lock_gnt: one-hot locked grant; reset value 0.
  - state: IDLE or LOCK; reset value IDLE.
- Pick in IDLE: pick = the first i with in_valid[i] set, scanning upward from the index of pri inclusive and wrapping modulo NUM_REQ. pick = 0 when no in_valid is set.
- Grant: gnt = pick in IDLE; gnt = lock_gnt in LOCK.
- Outputs (no ARB_OUT_REG_EN):
  - out_valid = |(in_valid & gnt).
  - out_data, out_last, out_id are muxed by gnt; out_id = 0 when gnt = 0.
  - in_ready[i] = gnt[i] & out_ready.
  - Latency is 0 cycles, purely combinational.
- Accept: accept = out_valid & out_ready.
- Transitions from IDLE:
  - accept & out_last: stay IDLE; pri <= gnt rotated left by 1 (bit NUM_REQ-1 wraps to bit 0).
  - out_valid & ~(accept & out_last): go to LOCK; lock_gnt <= pick. This covers both "offered but stalled" and "accepted non-last beat", so an offered beat's source never changes.
  - no in_valid: hold all state; pri unchanged.
- Transitions from LOCK:
  - Other requesters are ignored; their in_ready stays 0.
  - accept & out_last: go to IDLE; pri <= lock_gnt rotated left by 1; lock_gnt <= 0.
  - Locked requester deasserts in_valid between beats: out_valid = 0; stay LOCK; no timeout.
- busy = (state == LOCK).
- Single-beat packets with out_ready held high never enter LOCK; consecutive picks rotate every cycle.
- Reset mid-packet: next cycle state = IDLE, pri = 1, lock_gnt = 0. The partial packet is abandoned; flushing it downstream is the owner's responsibility.
- NUM_REQ = 2: the rotate is a swap. Wrap-around scanning stays correct.
- No X propagation: with gnt = 0, out_data = 0 and out_last = 0.

Optional Feature:
- ARB_OUT_REG_EN defined:
  - A 2-entry skid buffer registers out_valid, out_data, out_last and out_id.
  - in_ready[i] = gnt[i] & ~skid_full, where skid_full means 2 entries are held.
  - "accept" in the FSM becomes the upstream handshake (in_valid & in_ready for the granted source) instead of the downstream one.
  - Latency is 1 cycle from upstream accept to out_valid.
  - Throughput is 1 beat/cycle while out_ready is high. out_* hold stable while out_valid & ~out_ready.
  - Reset empties the skid buffer; out_valid = 0 the cycle after rst.
- ARB_OUT_REG_EN undefined: combinational path exactly as in Behaviour.

Test Plan:
1. Reset, then in_valid = 4'b1111, all in_last = 1, out_ready = 1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3; busy stays 0.
2. Requester 2 sends a 3-beat packet (D0, D1, D2, last on D2) while requesters 0/1/3 hold valid -> out_data = D0, D1, D2 back-to-back with out_id = 2 and busy = 1 for beats 1-2. The next grant is requester 3.
3. in_valid = 4'b0101, out_ready = 0 for 5 cycles, then 1 -> out_id stays 0 while stalled and in_ready = 0. On release requester 0 is accepted, then requester 2.
4. Requester 1 is locked mid-packet and drops in_valid for 3 cycles while requester 3 is valid -> out_valid = 0 and in_ready[3] = 0 throughout. Requester 1 then finishes, after which requester 3 is granted.
5. Assert rst during beat 2 of a 4-beat packet from requester 3 -> next cycle busy = 0, out_id = 0, pri = 1. A valid from requester 0 is granted first.
6. With ARB_OUT_REG_EN, in_valid = 4'b0011, all single-beat, out_ready toggling 1,0,1,0 -> each out_valid rises 1 cycle after acceptance. The out_id order is 0,1,0,1 with no lost or duplicated beat. in_ready drops when the skid buffer holds 2 entries.
